// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue.
package if_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  // One queue slot: fetch PC, returned word, data-present flag, misaligned-fetch flag.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
    logic        adel;
  } if_entry_t;

endpackage

// File: rtl/if_entry_queue.sv
// Circular buffer of fetch entries: allocate at tail, fill in order, pop at head.
module if_entry_queue
  import if_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clear,
  input  logic             alloc,
  input  if_entry_t        alloc_entry,
  input  logic             fill,
  input  logic [31:0]      fill_data,
  input  logic             pop,
  output if_entry_t        head,
  output logic [CNT_W-1:0] used
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] used_q, used_d;
  if_entry_t        mem_q [DEPTH];

  // Pointer and occupancy update; clear wins over every other request.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    used_d = used_q;
    if (clear) begin
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      used_d = '0;
    end else begin
      if (alloc) begin
        tail_d = tail_q + PTR_W'(1);
        // A pre-filled entry is only allocated with nothing pending, so fill pointer skips it.
        if (alloc_entry.filled) fill_d = fill_q + PTR_W'(1);
      end
      if (fill) fill_d = fill_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      case ({alloc, pop})
        2'b10:   used_d = used_q + CNT_W'(1);
        2'b01:   used_d = used_q - CNT_W'(1);
        default: used_d = used_q;
      endcase
    end
  end

  // Pointer registers and entry storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      used_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      used_q <= used_d;
      if (clear) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i].filled <= 1'b0;
      end else begin
        if (alloc) mem_q[tail_q] <= alloc_entry;
        if (fill) begin
          mem_q[fill_q].instr  <= fill_data;
          mem_q[fill_q].filled <= 1'b1;
        end
      end
    end
  end

  assign head = mem_q[head_q];
  assign used = used_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front end: sequential PC generation, bus request issue, in-order buffering for decode.
module instr_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = if_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  input  logic        id_stall_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic        id_adel_o
);

  import if_pkg::if_entry_t;
  import if_pkg::NOP;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OST_W = $clog2(MAX_OUTST + 1);

  logic [31:0]      pc_q, pc_d;
  logic             run_q, run_d;
  logic             halt_q, halt_d;
  logic [OST_W-1:0] outst_q, outst_d;
  logic [OST_W-1:0] disc_q, disc_d;

  logic [CNT_W-1:0] used;
  if_entry_t        head;
  if_entry_t        alloc_entry;
  logic             space;
  logic             bus_quiet;
  logic             data_ok_v;
  logic             hs;
  logic             misal_alloc;
  logic             alloc;
  logic             fill;
  logic             pop;
  logic             head_valid;

  // Issue/allocation qualifiers derived from current state.
  always_comb begin
    space       = used < CNT_W'(DEPTH);
    bus_quiet   = (outst_q == '0) && (disc_q == '0);
    data_ok_v   = inst_data_ok_i && !bus_quiet;
    inst_req_o  = run_q && !redirect_i && space && (outst_q < OST_W'(MAX_OUTST))
                  && (disc_q == '0) && (pc_q[1:0] == 2'b00);
    hs          = inst_req_o && inst_addr_ok_i;
    misal_alloc = run_q && !redirect_i && !halt_q && space && bus_quiet
                  && (pc_q[1:0] != 2'b00);
    alloc       = hs || misal_alloc;
    alloc_entry = '{pc: pc_q, instr: NOP, filled: misal_alloc, adel: misal_alloc};
    fill        = data_ok_v && (disc_q == '0) && !redirect_i;
    head_valid  = (used != '0) && head.filled;
    pop         = head_valid && !id_stall_i && !redirect_i;
  end

  // Next PC, outstanding and discard counts; a redirect folds in-flight requests into discard.
  always_comb begin
    pc_d    = pc_q;
    run_d   = 1'b1;
    halt_d  = halt_q;
    outst_d = outst_q;
    disc_d  = disc_q;
    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      halt_d  = 1'b0;
      outst_d = '0;
      disc_d  = outst_q + disc_q - OST_W'(data_ok_v);
    end else begin
      if (hs)          pc_d   = pc_q + 32'd4;
      if (misal_alloc) halt_d = 1'b1;
      if (data_ok_v && (disc_q != '0)) disc_d = disc_q - OST_W'(1);
      outst_d = outst_q + OST_W'(hs) - OST_W'(fill);
    end
  end

  // Fetch control state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q    <= RESET_PC;
      run_q   <= 1'b0;
      halt_q  <= 1'b0;
      outst_q <= '0;
      disc_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      run_q   <= run_d;
      halt_q  <= halt_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
    end
  end

  if_entry_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (redirect_i),
    .alloc       (alloc),
    .alloc_entry (alloc_entry),
    .fill        (fill),
    .fill_data   (inst_rdata_i),
    .pop         (pop),
    .head        (head),
    .used        (used)
  );

  // Decode-side view of the head entry; NOP whenever nothing valid or an address error.
  always_comb begin
    inst_addr_o = pc_q;
    id_valid_o  = head_valid;
    id_instr_o  = (head_valid && !head.adel) ? head.instr : NOP;
    id_pc_o     = head_valid ? head.pc : 32'h0;
    id_adel_o   = head_valid && head.adel;
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: bus responder plus in-order scoreboard.
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;
  localparam logic [31:0] RST_PC    = 32'hBFC0_0000;
  localparam int          BIG       = 1 << 30;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        stale;
  } bus_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_req_o;
  logic [31:0] inst_addr_o;
  logic        inst_addr_ok_i = 1'b0;
  logic        inst_data_ok_i = 1'b0;
  logic [31:0] inst_rdata_i = '0;
  logic        id_stall_i = 1'b0;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_adel_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Bus responder and scoreboard state.
  logic        bus_accept = 1'b1;
  int          data_budget = BIG;
  bus_t        bus_q[$];
  exp_t        sb[$];
  int          stale_cnt = 0;
  logic [31:0] exp_pc = RST_PC;
  int          stale_start, live_start, used_start;
  bus_t        be;
  exp_t        ee;

  instr_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .inst_req_o     (inst_req_o),
    .inst_addr_o    (inst_addr_o),
    .inst_addr_ok_i (inst_addr_ok_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .id_stall_i     (id_stall_i),
    .id_valid_o     (id_valid_o),
    .id_instr_o     (id_instr_o),
    .id_pc_o        (id_pc_o),
    .id_adel_o      (id_adel_o)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Bus responder drives shortly after negedge; scoreboard samples late in the low phase.
  always begin
    @(negedge clk);
    #1;
    if (!resetn) begin
      inst_addr_ok_i = 1'b0;
      inst_data_ok_i = 1'b0;
      inst_rdata_i   = '0;
    end else begin
      inst_addr_ok_i = bus_accept;
      if (bus_q.size() > 0 && data_budget > 0) begin
        inst_data_ok_i = 1'b1;
        inst_rdata_i   = word_of(bus_q[0].addr);
      end else begin
        inst_data_ok_i = 1'b0;
        inst_rdata_i   = 32'hDEAD_BEEF;
      end
    end
    #7;
    if (!resetn) begin
      bus_q.delete();
      sb.delete();
      stale_cnt = 0;
      exp_pc    = RST_PC;
    end else begin
      stale_start = stale_cnt;
      live_start  = bus_q.size() - stale_cnt;
      used_start  = sb.size();
      assert (!inst_data_ok_i || bus_q.size() > 0);
      if (inst_req_o) begin
        n_cmp++;
        if (redirect_i || stale_start != 0 || live_start >= int'(MAX_OUTST) ||
            used_start >= int'(DEPTH) || exp_pc[1:0] != 2'b00 || inst_addr_o !== exp_pc) begin
          n_bad++;
          $display("FAIL req_issue: addr=%h redirect=%0b stale=%0d outst=%0d used=%0d required addr=%h",
                   inst_addr_o, redirect_i, stale_start, live_start, used_start, exp_pc);
        end
      end
      if (inst_data_ok_i) begin
        be = bus_q.pop_front();
        if (be.stale) stale_cnt--;
        data_budget--;
      end
      if (redirect_i) begin
        sb.delete();
        for (int i = 0; i < bus_q.size(); i++) bus_q[i].stale = 1'b1;
        stale_cnt = bus_q.size();
        exp_pc    = redirect_pc_i;
        if (redirect_pc_i[1:0] != 2'b00) begin
          ee.pc = redirect_pc_i; ee.instr = 32'h0; ee.adel = 1'b1;
          sb.push_back(ee);
        end
      end else begin
        if (id_valid_o && !id_stall_i) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL dequeue_empty: pc=%h instr=%h required no valid entry", id_pc_o, id_instr_o);
          end else begin
            ee = sb.pop_front();
            if ({id_pc_o, id_instr_o, id_adel_o} !== {ee.pc, ee.instr, ee.adel}) begin
              n_bad++;
              $display("FAIL dequeue: pc=%h instr=%h adel=%0b required pc=%h instr=%h adel=%0b",
                       id_pc_o, id_instr_o, id_adel_o, ee.pc, ee.instr, ee.adel);
            end
          end
        end
        if (inst_req_o && inst_addr_ok_i) begin
          ee.pc = exp_pc; ee.instr = word_of(exp_pc); ee.adel = 1'b0;
          sb.push_back(ee);
          be.addr = exp_pc; be.stale = 1'b0;
          bus_q.push_back(be);
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  end

  task automatic test_reset;
    resetn = 1'b0; id_stall_i = 1'b0; redirect_i = 1'b0;
    bus_accept = 1'b1; data_budget = BIG;
    repeat (3) @(negedge clk);
    #2;
    n_cmp++;
    if ({inst_req_o, id_valid_o, id_adel_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: req=%0b valid=%0b adel=%0b required 0 0 0", inst_req_o, id_valid_o, id_adel_o);
    end
    n_cmp++;
    if (id_instr_o !== 32'h0) begin n_bad++; $display("FAIL reset_instr: %h required 0", id_instr_o); end
    n_cmp++;
    if (id_pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_pc: %h required 0", id_pc_o); end
  endtask

  // Free-running stream from reset: first valid in cycle 3, then one instruction per cycle.
  task automatic test_stream;
    int lat;
    @(negedge clk);
    resetn = 1'b1;
    #2;
    n_cmp++;
    if (inst_req_o !== 1'b0) begin n_bad++; $display("FAIL stream_no_req_c0: req=%0b required 0", inst_req_o); end
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); #2;
      if (id_valid_o === 1'b1) begin lat = k; break; end
    end
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL stream_latency: %0d cycles required 3", lat); end
    for (int k = 0; k < 8; k++) begin
      if (k != 0) begin @(negedge clk); #2; end
      n_cmp++;
      if ({id_valid_o, id_pc_o, id_instr_o} !== {1'b1, RST_PC + 32'(4 * k), word_of(RST_PC + 32'(4 * k))}) begin
        n_bad++;
        $display("FAIL stream_head%0d: valid=%0b pc=%h instr=%h required pc=%h", k, id_valid_o, id_pc_o,
                 id_instr_o, RST_PC + 32'(4 * k));
      end
    end
  endtask

  // Decode stalled from reset: queue fills, head held; release drains back-to-back.
  task automatic test_stall;
    @(negedge clk);
    resetn = 1'b0; id_stall_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      n_cmp++;
      if ({id_valid_o, id_pc_o, inst_req_o} !== {1'b1, RST_PC, 1'b0}) begin
        n_bad++;
        $display("FAIL stall_hold%0d: valid=%0b pc=%h req=%0b required 1 %h 0", i, id_valid_o, id_pc_o,
                 inst_req_o, RST_PC);
      end
    end
    @(negedge clk);
    id_stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge clk);
      #2;
      n_cmp++;
      if ({id_valid_o, id_pc_o} !== {1'b1, RST_PC + 32'(4 * k)}) begin
        n_bad++;
        $display("FAIL drain%0d: valid=%0b pc=%h required 1 %h", k, id_valid_o, id_pc_o, RST_PC + 32'(4 * k));
      end
      if (k == 1) begin
        n_cmp++;
        if ({inst_req_o, inst_addr_o} !== {1'b1, 32'hBFC0_0010}) begin
          n_bad++;
          $display("FAIL resume_addr: req=%0b addr=%h required 1 bfc00010", inst_req_o, inst_addr_o);
        end
      end
    end
  endtask

  // Redirect with two requests in flight: both responses dropped, no issue until discard drains.
  task automatic test_redirect_discard;
    int got;
    @(negedge clk);
    data_budget = 0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (bus_q.size() == 2) begin got = 1; break; end
    end
    n_cmp++;
    if (got != 1) begin n_bad++; $display("FAIL outst_two: outstanding=%0d required 2", bus_q.size()); end
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_1000;
    @(negedge clk);
    redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #2;
      n_cmp++;
      if ({inst_req_o, id_valid_o, id_instr_o} !== {1'b0, 1'b0, 32'h0}) begin
        n_bad++;
        $display("FAIL discard_wait%0d: req=%0b valid=%0b instr=%h required 0 0 0", i, inst_req_o, id_valid_o, id_instr_o);
      end
    end
    @(negedge clk);
    data_budget = BIG;
    for (int i = 0; i < 3; i++) begin
      if (i != 0) @(negedge clk);
      #2;
      n_cmp++;
      if (i < 2 && inst_req_o !== 1'b0) begin
        n_bad++;
        $display("FAIL discard_drain%0d: req=%0b required 0", i, inst_req_o);
      end else if (i == 2 && {inst_req_o, inst_addr_o} !== {1'b1, 32'h8000_1000}) begin
        n_bad++;
        $display("FAIL redirect_first_req: req=%0b addr=%h required 1 80001000", inst_req_o, inst_addr_o);
      end
    end
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (id_valid_o === 1'b1) begin got = 1; break; end
    end
    n_cmp++;
    if (got != 1 || {id_pc_o, id_instr_o} !== {32'h8000_1000, word_of(32'h8000_1000)}) begin
      n_bad++;
      $display("FAIL redirect_first_word: valid=%0b pc=%h instr=%h required pc=80001000 instr=%h",
               id_valid_o, id_pc_o, id_instr_o, word_of(32'h8000_1000));
    end
  endtask

  // Misaligned target: address-error entry presented and held, no bus traffic, until next redirect.
  task automatic test_misaligned;
    int got;
    @(negedge clk);
    id_stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h8000_1002;
    @(negedge clk);
    redirect_i = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (id_valid_o === 1'b1) begin got = 1; break; end
    end
    n_cmp++;
    if (got != 1 || {id_adel_o, id_instr_o, id_pc_o} !== {1'b1, 32'h0, 32'h8000_1002}) begin
      n_bad++;
      $display("FAIL adel_entry: valid=%0b adel=%0b instr=%h pc=%h required 1 1 0 80001002",
               id_valid_o, id_adel_o, id_instr_o, id_pc_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      n_cmp++;
      if ({id_valid_o, id_adel_o, id_pc_o, inst_req_o} !== {1'b1, 1'b1, 32'h8000_1002, 1'b0}) begin
        n_bad++;
        $display("FAIL adel_hold%0d: valid=%0b adel=%0b pc=%h req=%0b required 1 1 80001002 0",
                 i, id_valid_o, id_adel_o, id_pc_o, inst_req_o);
      end
    end
    @(negedge clk);
    id_stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_2000;
    @(negedge clk);
    redirect_i = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (id_valid_o === 1'b1) begin got = 1; break; end
    end
    n_cmp++;
    if (got != 1 || {id_adel_o, id_pc_o} !== {1'b0, 32'h8000_2000}) begin
      n_bad++;
      $display("FAIL adel_recover: valid=%0b adel=%0b pc=%h required 1 0 80002000", id_valid_o, id_adel_o, id_pc_o);
    end
  endtask

  // Redirect colliding with data_ok and a would-be dequeue while one request is outstanding.
  task automatic test_redirect_collide;
    int got;
    @(negedge clk);
    id_stall_i = 1'b1; data_budget = BIG; bus_accept = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (sb.size() == int'(DEPTH) && bus_q.size() == 0) begin got = 1; break; end
    end
    n_cmp++;
    if (got != 1) begin n_bad++; $display("FAIL collide_fill: used=%0d outst=%0d required 4 0", sb.size(), bus_q.size()); end
    @(negedge clk);
    data_budget = 0; id_stall_i = 1'b0;
    @(negedge clk);
    id_stall_i = 1'b1;
    @(negedge clk);
    bus_accept = 1'b0;
    #2;
    n_cmp++;
    if (bus_q.size() != 1 || id_valid_o !== 1'b1) begin
      n_bad++;
      $display("FAIL collide_setup: outst=%0d valid=%0b required 1 1", bus_q.size(), id_valid_o);
    end
    @(negedge clk);
    id_stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_3000; data_budget = 1;
    #2;
    n_cmp++;
    if ({inst_req_o, inst_data_ok_i} !== 2'b01) begin
      n_bad++;
      $display("FAIL collide_cycle: req=%0b data_ok=%0b required 0 1", inst_req_o, inst_data_ok_i);
    end
    @(negedge clk);
    redirect_i = 1'b0; bus_accept = 1'b1; data_budget = BIG;
    #2;
    n_cmp++;
    if ({inst_req_o, inst_addr_o, id_valid_o} !== {1'b1, 32'h8000_3000, 1'b0}) begin
      n_bad++;
      $display("FAIL collide_restart: req=%0b addr=%h valid=%0b required 1 80003000 0",
               inst_req_o, inst_addr_o, id_valid_o);
    end
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (id_valid_o === 1'b1) begin got = 1; break; end
    end
    n_cmp++;
    if (got != 1 || id_pc_o !== 32'h8000_3000) begin
      n_bad++;
      $display("FAIL collide_word: valid=%0b pc=%h required 1 80003000", id_valid_o, id_pc_o);
    end
  endtask

  // Reset asserted with a full queue and two requests in flight.
  task automatic test_reset_midop;
    int got;
    @(negedge clk);
    id_stall_i = 1'b1; bus_accept = 1'b0; data_budget = BIG;
    for (int i = 0; i < 10 && bus_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_4000; bus_accept = 1'b1; data_budget = 2;
    @(negedge clk);
    redirect_i = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #2;
      if (sb.size() == int'(DEPTH) && bus_q.size() == 2) begin got = 1; break; end
    end
    n_cmp++;
    if (got != 1) begin n_bad++; $display("FAIL midop_setup: used=%0d outst=%0d required 4 2", sb.size(), bus_q.size()); end
    @(negedge clk);
    resetn = 1'b0;
    #2;
    n_cmp++;
    if ({inst_req_o, id_valid_o, id_adel_o, id_instr_o, id_pc_o} !== 67'h0) begin
      n_bad++;
      $display("FAIL midop_reset: req=%0b valid=%0b adel=%0b instr=%h pc=%h required all 0",
               inst_req_o, id_valid_o, id_adel_o, id_instr_o, id_pc_o);
    end
    @(negedge clk);
    resetn = 1'b1; data_budget = BIG; id_stall_i = 1'b0;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (inst_req_o === 1'b1) begin got = 1; break; end
    end
    n_cmp++;
    if (got != 1 || inst_addr_o !== RST_PC) begin
      n_bad++;
      $display("FAIL midop_restart: req=%0b addr=%h required 1 %h", inst_req_o, inst_addr_o, RST_PC);
    end
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (id_valid_o === 1'b1) begin got = 1; break; end
    end
    n_cmp++;
    if (got != 1 || id_pc_o !== RST_PC) begin
      n_bad++;
      $display("FAIL midop_first_word: valid=%0b pc=%h required 1 %h", id_valid_o, id_pc_o, RST_PC);
    end
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_discard();
    test_misaligned();
    test_redirect_collide();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
